// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_pkg: shared widths, lane vector types and requant saturators    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conv_pkg;

   localparam int LANES  = 8;
   localparam int PIX_W  = 8;
   localparam int WT_W   = 8;
   localparam int PROD_W = 17;
   localparam int SUM_W  = 20;
   // Working width for the requantizer input; accumulators are sign-extended to it
   localparam int SAT_W  = 48;

   typedef logic        [PIX_W-1:0]  pix_vec_t  [LANES-1:0];
   typedef logic signed [WT_W-1:0]   wt_vec_t   [LANES-1:0];
   typedef logic signed [PROD_W-1:0] prod_vec_t [LANES-1:0];

   function automatic logic [7:0] sat_u8(input logic signed [SAT_W-1:0] x);
      if (x < SAT_W'(0))
         return 8'h00;
      else if (x > SAT_W'(255))
         return 8'hFF;
      else
         return x[7:0];
   endfunction

   function automatic logic [7:0] sat_s8(input logic signed [SAT_W-1:0] x);
      if (x > SAT_W'(127))
         return 8'h7F;
      else if (x < SAT_W'(-128))
         return 8'h80;
      else
         return x[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_tree8: registered 8-input signed sum, 1-cycle latency, tagged  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adder_tree8
   import conv_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  prod_vec_t               prod,
   input  logic                    in_vld,
   input  logic                    in_first,
   input  logic                    in_last,
   output logic signed [SUM_W-1:0] sum,
   output logic                    out_vld,
   output logic                    out_first,
   output logic                    out_last
);

   logic signed [PROD_W:0]   w_l1 [4];
   logic signed [PROD_W+1:0] w_l2 [2];
   logic signed [SUM_W-1:0]  w_l3;

   logic signed [SUM_W-1:0]  r_sum;
   logic                     r_vld;
   logic                     r_first;
   logic                     r_last;

   // Each level grows one bit so no partial sum can overflow
   for (genvar i = 0; i < 4; i++) begin : g_l1
      assign w_l1[i] = (PROD_W+1)'(prod[2*i]) + (PROD_W+1)'(prod[2*i+1]);
   end

   for (genvar i = 0; i < 2; i++) begin : g_l2
      assign w_l2[i] = (PROD_W+2)'(w_l1[2*i]) + (PROD_W+2)'(w_l1[2*i+1]);
   end

   assign w_l3 = SUM_W'(w_l2[0]) + SUM_W'(w_l2[1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= '0;
         r_vld   <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_sum   <= w_l3;
         r_vld   <= in_vld;
         r_first <= in_vld & in_first;
         r_last  <= in_vld & in_last;
      end
   end

   assign sum       = r_sum;
   assign out_vld   = r_vld;
   assign out_first = r_first;
   assign out_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/conv_mac8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_mac8: 8-lane window MAC, NUM_BEATS beats + bias -> requant int8 |
// | Option macro CONV_MAC_RELU_EN: fused ReLU, unsigned 0..255 output    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_mac8
   import conv_pkg::*;
#(
   parameter int NUM_BEATS = 3,
   parameter int SHIFT     = 8,
   parameter int ACC_W     = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  pix_vec_t    pix_in,
   input  logic        pix_rdy,
   output logic        pix_consumed,
   input  logic        wt_wr_en,
   input  logic [4:0]  wt_addr,
   input  logic [31:0] wt_data,
   output logic [7:0]  out_data,
   output logic        out_vld,
   input  logic        out_rdy,
   output logic [1:0]  beat_idx
);

   localparam logic [1:0] c_LAST_BEAT = 2'(NUM_BEATS-1);
   localparam logic [4:0] c_NUM_WT    = 5'(LANES*NUM_BEATS);
   localparam logic [4:0] c_BIAS_ADDR = 5'd31;

   logic signed [WT_W-1:0]  r_wt [NUM_BEATS][LANES];
   logic signed [ACC_W-1:0] r_bias;
   logic [1:0]              r_beat_idx;

   prod_vec_t               w_prod;
   prod_vec_t               r_s1_prod;
   logic                    r_s1_vld;
   logic                    r_s1_first;
   logic                    r_s1_last;

   logic signed [SUM_W-1:0] w_s2_sum;
   logic                    w_s2_vld;
   logic                    w_s2_first;
   logic                    w_s2_last;

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_acc_new;
   logic signed [ACC_W-1:0] w_shift;
   logic signed [SAT_W-1:0] w_sat_in;
   logic [7:0]              w_q;
   logic [7:0]              r_out_data;
   logic                    r_out_vld;

   logic                    w_clear;
   logic                    w_last_beat;
   logic                    w_stall;
   logic                    w_accept;

   assign w_clear     = rst | clr;
   assign w_last_beat = (r_beat_idx == c_LAST_BEAT);

   // A last beat in flight must reach the output register before the next group may start
   assign w_stall  = (r_s1_vld & r_s1_last) | (w_s2_vld & w_s2_last) | (r_out_vld & ~out_rdy);
   assign w_accept = pix_rdy & ~w_stall & ~w_clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int g = 0; g < NUM_BEATS; g++) begin
            for (int i = 0; i < LANES; i++) begin
               r_wt[g][i] <= '0;
            end
         end
         r_bias <= '0;
      end else if (!clr && wt_wr_en) begin
         if (wt_addr == c_BIAS_ADDR)
            r_bias <= wt_data[ACC_W-1:0];
         else if (wt_addr < c_NUM_WT)
            r_wt[wt_addr[4:3]][wt_addr[2:0]] <= wt_data[WT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear)
         r_beat_idx <= 2'd0;
      else if (w_accept)
         r_beat_idx <= w_last_beat ? 2'd0 : r_beat_idx + 2'd1;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_prod[i] = PROD_W'($signed({1'b0, pix_in[i]})) * PROD_W'(r_wt[r_beat_idx][i]);

      always_ff @(posedge clk) begin
         if (w_accept)
            r_s1_prod[i] <= w_prod[i];
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_s1_vld   <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
      end else begin
         r_s1_vld   <= w_accept;
         r_s1_first <= w_accept & (r_beat_idx == 2'd0);
         r_s1_last  <= w_accept & w_last_beat;
      end
   end

   adder_tree8 u_adder_tree8 (
      .clk       (clk),
      .rst       (w_clear),
      .prod      (r_s1_prod),
      .in_vld    (r_s1_vld),
      .in_first  (r_s1_first),
      .in_last   (r_s1_last),
      .sum       (w_s2_sum),
      .out_vld   (w_s2_vld),
      .out_first (w_s2_first),
      .out_last  (w_s2_last)
   );

   assign w_acc_new = (w_s2_first ? r_bias : r_acc) + ACC_W'(w_s2_sum);
   assign w_shift   = w_acc_new >>> SHIFT;
   assign w_sat_in  = SAT_W'(w_shift);

`ifdef CONV_MAC_RELU_EN
   assign w_q = sat_u8(w_sat_in);
`else
   assign w_q = sat_s8(w_sat_in);
`endif

   // A fresh result outranks the drain of the previous one in the same cycle
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_acc      <= '0;
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
      end else begin
         if (w_s2_vld)
            r_acc <= w_acc_new;
         if (w_s2_vld && w_s2_last) begin
            r_out_data <= w_q;
            r_out_vld  <= 1'b1;
         end else if (out_rdy) begin
            r_out_vld  <= 1'b0;
         end
      end
   end

   assign pix_consumed = w_accept;
   assign out_data     = r_out_data;
   assign out_vld      = r_out_vld;
   assign beat_idx     = r_beat_idx;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_mac8: directed vectors on three SHIFT variants (0, 2, 8)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_conv_mac8;
   import conv_pkg::*;

   typedef struct packed {
      int         w;
      int         p;
      int         b;
      logic [7:0] r0, r2, r8;
      logic [7:0] s0, s2, s8;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, clr, pix_rdy, wt_wr_en, out_rdy;
   pix_vec_t    pix;
   logic [4:0]  wt_addr;
   logic [31:0] wt_data;
   logic [7:0]  od [3];
   logic        ov [3];
   logic        pc [3];
   logic [1:0]  bi [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv_mac8 #(.NUM_BEATS(3), .SHIFT(0), .ACC_W(32)) u_s0 (
      .clk(clk), .rst(rst), .clr(clr), .pix_in(pix), .pix_rdy(pix_rdy),
      .pix_consumed(pc[0]), .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .out_data(od[0]), .out_vld(ov[0]), .out_rdy(out_rdy), .beat_idx(bi[0]));

   conv_mac8 #(.NUM_BEATS(3), .SHIFT(2), .ACC_W(32)) u_s2 (
      .clk(clk), .rst(rst), .clr(clr), .pix_in(pix), .pix_rdy(pix_rdy),
      .pix_consumed(pc[1]), .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .out_data(od[1]), .out_vld(ov[1]), .out_rdy(out_rdy), .beat_idx(bi[1]));

   conv_mac8 #(.NUM_BEATS(3), .SHIFT(8), .ACC_W(32)) u_s8 (
      .clk(clk), .rst(rst), .clr(clr), .pix_in(pix), .pix_rdy(pix_rdy),
      .pix_consumed(pc[2]), .wt_wr_en(wt_wr_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .out_data(od[2]), .out_vld(ov[2]), .out_rdy(out_rdy), .beat_idx(bi[2]));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mkv(input int w, input int p, input int b,
                                input logic [7:0] r0, input logic [7:0] r2, input logic [7:0] r8,
                                input logic [7:0] s0, input logic [7:0] s2, input logic [7:0] s8);
      vec_t v;
      v.w = w; v.p = p; v.b = b;
      v.r0 = r0; v.r2 = r2; v.r8 = r8;
      v.s0 = s0; v.s2 = s2; v.s8 = s8;
      return v;
   endfunction

   function automatic pix_vec_t fill(input int p);
      pix_vec_t r;
      for (int i = 0; i < LANES; i++) r[i] = 8'(p);
      return r;
   endfunction

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wt_addr  = a;
      wt_data  = d;
      wt_wr_en = 1'b1;
      @(posedge clk); #1;
      wt_wr_en = 1'b0;
   endtask

   task automatic set_uniform(input int w, input int b);
      for (int a = 0; a < 24; a++) wr(5'(a), 32'(w));
      wr(5'd31, 32'(b));
      wr(5'd24, 32'h7F);
      wr(5'd30, 32'h7F);
   endtask

   // Present one beat and wait (bounded) for it to be taken; returns at posedge+1
   task automatic send_beat(input pix_vec_t p, input int g, input string nm);
      bit got = 0;
      pix     = p;
      pix_rdy = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (pc[0]) begin
            got = 1;
            chk({nm, " beat_idx"}, int'(bi[0]), g);
         end
         @(posedge clk); #1;
         if (got) break;
      end
      pix_rdy = 1'b0;
      if (!got) chk({nm, " consume timeout"}, 0, 1);
   endtask

   task automatic run_group(input pix_vec_t p0, input pix_vec_t p1, input pix_vec_t p2,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input string nm);
      int lat = 0;
      send_beat(p0, 0, nm);
      send_beat(p1, 1, nm);
      send_beat(p2, 2, nm);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (ov[0]) begin
            lat = k;
            break;
         end
      end
      chk({nm, " latency"}, lat, 3);
      chk({nm, " vld s2"}, int'(ov[1]), 1);
      chk({nm, " vld s8"}, int'(ov[2]), 1);
      chk({nm, " data s0"}, int'(od[0]), int'(e0));
      chk({nm, " data s2"}, int'(od[1]), int'(e1));
      chk({nm, " data s8"}, int'(od[2]), int'(e2));
      chk({nm, " beat_idx wrap"}, int'(bi[0]), 0);
      @(posedge clk); #1;
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
      @(negedge clk);
      chk({nm, " drained"}, int'(ov[0]), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt [7];
      pix_vec_t   lp [3];
      logic [14:0] epc;
      logic [14:0] eov;
      logic [7:0] ga [3];
      logic [7:0] gb [3];

      rst = 1'b1; clr = 1'b0; pix_rdy = 1'b0; wt_wr_en = 1'b0; out_rdy = 1'b0;
      wt_addr = '0; wt_data = '0; pix = fill(0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_vld", int'(ov[0]), 0);
      chk("reset out_data", int'(od[0]), 0);
      chk("reset beat_idx", int'(bi[0]), 0);
      @(posedge clk); #1;

      //            w    p    b      relu s0/s2/s8        signed s0/s2/s8
      vt[0] = mkv(  1,   2,    0, 8'd48, 8'd12, 8'd0,  8'd48, 8'd12, 8'd0);
      vt[1] = mkv( -1,  10,    0, 8'd0,  8'd0,  8'd0,  8'h80, 8'hC4, 8'hFF);
      vt[2] = mkv(127, 255,    0, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F);
      vt[3] = mkv(  0,   5, 1000, 8'hFF, 8'd250, 8'd3, 8'h7F, 8'h7F, 8'd3);
      vt[4] = mkv(  0,   5,   -4, 8'd0,  8'd0,  8'd0,  8'hFC, 8'hFF, 8'hFF);
      vt[5] = mkv(  3,   7, -100, 8'hFF, 8'd101, 8'd1, 8'h7F, 8'd101, 8'd1);
      vt[6] = mkv( -2, 100, 5000, 8'd200, 8'd50, 8'd0, 8'h7F, 8'd50, 8'd0);

      for (int v = 0; v < 7; v++) begin
         set_uniform(vt[v].w, vt[v].b);
`ifdef CONV_MAC_RELU_EN
         run_group(fill(vt[v].p), fill(vt[v].p), fill(vt[v].p),
                   vt[v].r0, vt[v].r2, vt[v].r8, $sformatf("vec%0d", v));
`else
         run_group(fill(vt[v].p), fill(vt[v].p), fill(vt[v].p),
                   vt[v].s0, vt[v].s2, vt[v].s8, $sformatf("vec%0d", v));
`endif
      end

      // Lane- and group-distinct weights: w[g][i] = i-g, pixel = 10g+i+1, acc = 836-800 = 36
      for (int g = 0; g < 3; g++)
         for (int i = 0; i < LANES; i++) begin
            wr(5'(g*8+i), 32'(i-g));
            lp[g][i] = 8'(10*g + i + 1);
         end
      wr(5'd31, 32'(-800));
      run_group(lp[0], lp[1], lp[2], 8'd36, 8'd9, 8'd0, "lanes");

      // Backpressure over two groups; bit c of each mask is the expectation for cycle c
      set_uniform(1, 0);
      epc = 15'h0707;
      eov = 15'h21E0;
      ga[0] = 8'd48; ga[1] = 8'd12; ga[2] = 8'd0;
      gb[0] = 8'd72; gb[1] = 8'd18; gb[2] = 8'd0;
      for (int c = 0; c < 15; c++) begin
         pix     = (c < 3) ? fill(2) : fill(3);
         pix_rdy = (c <= 10);
         out_rdy = (c >= 8);
         @(negedge clk);
         chk($sformatf("stall pc c%0d", c), int'(pc[0]), int'(epc[c]));
         chk($sformatf("stall vld c%0d", c), int'(ov[0]), int'(eov[c]));
         if (eov[c]) begin
            for (int d = 0; d < 3; d++)
               chk($sformatf("stall data c%0d d%0d", c, d), int'(od[d]),
                   (c < 12) ? int'(ga[d]) : int'(gb[d]));
         end
         @(posedge clk); #1;
      end
      pix_rdy = 1'b0;
      out_rdy = 1'b0;
      @(posedge clk); #1;

      // clr mid-group keeps weights/bias: 7 + 48 = 55
      set_uniform(1, 7);
      send_beat(fill(2), 0, "clr");
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      chk("clr beat_idx", int'(bi[0]), 0);
      chk("clr out_vld", int'(ov[0]), 0);
      @(posedge clk); #1;
      run_group(fill(2), fill(2), fill(2), 8'd55, 8'd13, 8'd0, "after_clr");

      // rst mid-group zeroes weights and bias
      send_beat(fill(2), 0, "rst");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst beat_idx", int'(bi[0]), 0);
      chk("rst out_vld", int'(ov[0]), 0);
      chk("rst out_data", int'(od[0]), 0);
      @(posedge clk); #1;
      run_group(fill(2), fill(2), fill(2), 8'd0, 8'd0, 8'd0, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
